sync_fifo: RTL and testbench

Single-clock, first-in-first-out buffer for byte-wide data between a producer and a consumer in the same clock domain. It provides a registered read data output, full and empty flags, and a live occupancy counter. The counter is wide enough to represent both "empty" and "completely full".

---
 rtl/sync_fifo.sv | 80 ++++++++
 tb/tb_sync_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data, full/empty flags and an
// occupancy counter that spans 0..DEPTH so full and empty stay distinguishable.
module sync_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 6,
    parameter int COUNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_en,
    input  logic                   read_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   FIFO_full,
    output logic                   FIFO_empty,
    output logic [COUNT_WIDTH-1:0] FIFO_counter
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   wr_ok, rd_ok;

    // Flags decode the current (pre-edge) count, so acceptance uses it too.
    assign FIFO_full    = (count_q == FULL_COUNT);
    assign FIFO_empty   = (count_q == '0);
    assign FIFO_counter = count_q;
    assign data_out     = data_out_q;

    assign wr_ok = write_en & ~FIFO_full;
    assign rd_ok = read_en & ~FIFO_empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem_q[rd_ptr_q];
        end

        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is never cleared; reset only blocks the write in its own cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: constant vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       FIFO_full;
    logic       FIFO_empty;
    logic [6:0] FIFO_counter;

    int checks = 0;
    int failures = 0;
    string phase = "init";

    byte unsigned mq[$];
    logic [7:0]   m_dout = '0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (6),
        .COUNT_WIDTH(7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write_en    (write_en),
        .read_en     (read_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .FIFO_full   (FIFO_full),
        .FIFO_empty  (FIFO_empty),
        .FIFO_counter(FIFO_counter)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, name, act, exp);
        end
    endtask

    // Drives one cycle, advances the model by its rules, then compares after the edge.
    task automatic cycle(input logic r, input logic we, input logic re, input logic [7:0] din);
        rst      = r;
        write_en = we;
        read_en  = re;
        data_in  = din;
        if (r) begin
            mq.delete();
            m_dout = '0;
        end else begin
            bit was_full;
            bit was_empty;
            was_full  = (mq.size() == 64);
            was_empty = (mq.size() == 0);
            if (re && !was_empty) m_dout = mq.pop_front();
            if (we && !was_full) mq.push_back(din);
        end
        @(posedge clk);
        #1;
        chk("count", FIFO_counter, mq.size());
        chk("full", FIFO_full, mq.size() == 64);
        chk("empty", FIFO_empty, mq.size() == 0);
        chk("data_out", data_out, m_dout);
    endtask

    typedef struct {
        logic       r;
        logic       we;
        logic       re;
        logic [7:0] din;
        int         exp_count;
        logic [7:0] exp_dout;
        logic       exp_full;
        logic       exp_empty;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs = '{
            '{1'b1, 1'b1, 1'b0, 8'hFF, 0, 8'h00, 1'b0, 1'b1},
            '{1'b1, 1'b1, 1'b0, 8'hFF, 0, 8'h00, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b0, 8'h11, 1, 8'h00, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b0, 8'h22, 2, 8'h00, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h11, 1'b0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 8'h33, 1, 8'h22, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0, 1'b1},
            '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h33, 1'b0, 1'b1},
            '{1'b0, 1'b1, 1'b1, 8'h44, 1, 8'h33, 1'b0, 1'b0},
            '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h44, 1'b0, 1'b1}
        };

        phase = "table";
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].r, vecs[i].we, vecs[i].re, vecs[i].din);
            chk("tbl_count", FIFO_counter, vecs[i].exp_count);
            chk("tbl_dout", data_out, vecs[i].exp_dout);
            chk("tbl_full", FIFO_full, vecs[i].exp_full);
            chk("tbl_empty", FIFO_empty, vecs[i].exp_empty);
        end

        phase = "fill";
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 67; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'(i % 10));
            chk("fill_count", FIFO_counter, (i < 64) ? i + 1 : 64);
            chk("fill_full", FIFO_full, i >= 63);
        end

        phase = "drain";
        for (int i = 0; i < 70; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            chk("drain_dout", data_out, (i < 64) ? i % 10 : 3);
            chk("drain_count", FIFO_counter, (i < 64) ? 63 - i : 0);
        end

        phase = "simul";
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(200 + i));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 8'(50 + i));
            chk("simul_count", FIFO_counter, 5);
            chk("simul_dout", data_out, (i < 5) ? 200 + i : 50 + i - 5);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            chk("simul_tail", data_out, 55 + i);
        end
        cycle(1'b0, 1'b1, 1'b1, 8'h77);
        chk("both_empty_count", FIFO_counter, 1);
        chk("both_empty_dout", data_out, 59);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        chk("both_empty_read", data_out, 8'h77);
        for (int i = 0; i < 64; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i));
        chk("full_before", FIFO_full, 1);
        cycle(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("both_full_count", FIFO_counter, 63);
        chk("both_full_dout", data_out, 0);
        for (int i = 0; i < 63; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        chk("both_full_last", data_out, 63);
        chk("both_full_empty", FIFO_empty, 1);

        phase = "wrap";
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i + 7));
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'(100 + i));
            chk("wrap_nofull", FIFO_full, 0);
        end
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 8'h00);
            chk("wrap_dout", data_out, 100 + i);
        end
        chk("wrap_empty", FIFO_empty, 1);

        phase = "midrst";
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0, 8'(i + 1));
        chk("midrst_pre", FIFO_counter, 30);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk("midrst_count", FIFO_counter, 0);
        chk("midrst_empty", FIFO_empty, 1);
        chk("midrst_dout", data_out, 0);
        cycle(1'b0, 1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        chk("midrst_a5", data_out, 8'hA5);

        phase = "random";
        for (int blk = 0; blk < 12; blk++) begin
            int wp;
            wp = (blk % 3 == 0) ? 85 : ((blk % 3 == 1) ? 15 : 50);
            for (int i = 0; i < 250; i++) begin
                logic r;
                logic we;
                logic re;
                r  = ($urandom_range(0, 299) == 0);
                we = ($urandom_range(0, 99) < wp);
                re = ($urandom_range(0, 99) >= wp);
                if ($urandom_range(0, 9) == 0) re = we;
                cycle(r, we, re, 8'($urandom));
            end
        end

        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
